// File: rtl/tx_feeder_pkg.sv
// tx_feeder_pkg: shared state encoding, event codes and control bit layout for the TX sample feeder.
package tx_feeder_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TIME = 2'd1,
    RUN       = 2'd2,
    FLUSH     = 2'd3
  } state_t;
  typedef enum logic [2:0] {
    EV_NONE     = 3'd0,
    EV_ACK      = 3'd1,
    EV_UNDERRUN = 3'd2,
    EV_LATE     = 3'd4
  } ev_t;
  localparam int CLEAR_BIT  = 0;
  localparam int POLICY_BIT = 1;
endpackage

// File: rtl/setting_reg.sv
// setting_reg: setting-bus register latched on a write to its address.
module setting_reg #(
  parameter logic [7:0] MY_ADDR = 8'd0,
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] AT_RESET = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strobe,
  input  logic [7:0]       addr,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);
  always_ff @(posedge clk)
    if (rst) out <= AT_RESET;
    else if (strobe && addr == MY_ADDR) out <= in;
endmodule

// File: rtl/tx_time_compare.sv
// tx_time_compare: registered unsigned 64-bit now/late compare of vita_time against start_time.
module tx_time_compare (
  input  logic        dac_clk,
  input  logic        rst,
  input  logic [63:0] vita_time,
  input  logic [63:0] start_time,
  output logic        now,
  output logic        late
);
  always_ff @(posedge dac_clk)
    if (rst) begin
      now  <= 1'b0;
      late <= 1'b0;
    end else begin
      now  <= vita_time == start_time;
      late <= vita_time > start_time;
    end
endmodule

// File: rtl/tx_sample_feeder.sv
// tx_sample_feeder: pops FIFO sample words to the TX DSP core on strobe, with timed start,
// underrun/late detection and burst status events.
module tx_sample_feeder
  import tx_feeder_pkg::*;
#(
  parameter logic [7:0] BASE = 8'd0,
  parameter int CNT_W = 16
) (
  input  logic             dac_clk,
  input  logic             rst,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [31:0]      in_data,
  input  logic             in_eob,
  input  logic             in_src_rdy,
  output logic             in_dst_rdy,
  input  logic [63:0]      start_time,
  input  logic             start_time_valid,
  input  logic [63:0]      vita_time,
  output logic [31:0]      sample,
  output logic             run,
  input  logic             strobe,
  output logic             err_stb,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] underrun_count,
  output logic [31:0]      burst_samples
);
  state_t state, next_state;
  ev_t ev;
  logic policy, clear, kill, time_now, time_late, pop_run, underrun, unused_bits;
  assign clear = set_stb && set_addr == BASE && set_data[CLEAR_BIT];
  assign kill = rst | clear;
  assign unused_bits = ^set_data[31:2];
  setting_reg #(.MY_ADDR(BASE), .WIDTH(1), .AT_RESET(1'b0)) u_ctrl (
    .clk(dac_clk), .rst(rst), .strobe(set_stb), .addr(set_addr),
    .in(set_data[POLICY_BIT]), .out(policy)
  );
  tx_time_compare u_cmp (
    .dac_clk(dac_clk), .rst(rst), .vita_time(vita_time), .start_time(start_time),
    .now(time_now), .late(time_late)
  );
  assign pop_run  = ~kill & state == RUN & strobe & in_src_rdy;
  assign underrun = ~kill & state == RUN & strobe & ~in_src_rdy;
  assign in_dst_rdy = ~kill & in_src_rdy & (state == FLUSH | (state == RUN & strobe));
  assign sample = (state == RUN && in_src_rdy) ? in_data : 32'd0;
  assign err_code = ev;
  assign err_stb = ev != EV_NONE;
  always_comb begin
    next_state = state;
    ev = EV_NONE;
    case (state)
      IDLE:      next_state = in_src_rdy ? (start_time_valid ? WAIT_TIME : RUN) : IDLE;
      WAIT_TIME: next_state = time_now ? RUN : time_late ? FLUSH : WAIT_TIME;
      RUN:       next_state = (pop_run & in_eob) ? IDLE : (underrun & ~policy) ? FLUSH : RUN;
      FLUSH:     next_state = (in_src_rdy & in_eob) ? IDLE : FLUSH;
      default:   next_state = IDLE;
    endcase
    ev = kill ? EV_NONE
       : (state == WAIT_TIME && !time_now && time_late) ? EV_LATE
       : underrun ? EV_UNDERRUN
       : (pop_run && in_eob) ? EV_ACK
       : EV_NONE;
    if (kill) next_state = IDLE;
  end
  always_ff @(posedge dac_clk)
    if (rst) begin
      state          <= IDLE;
      run            <= 1'b0;
      underrun_count <= '0;
      burst_samples  <= '0;
    end else begin
      state <= next_state;
      run   <= next_state == RUN;
      underrun_count <= clear ? '0 : (underrun && !(&underrun_count)) ? underrun_count + 1'b1 : underrun_count;
      burst_samples  <= (clear || (state == IDLE && next_state != IDLE)) ? 32'd0
                      : pop_run ? burst_samples + 32'd1 : burst_samples;
    end
endmodule

// File: tb/tb_tx_sample_feeder.sv
// tb_tx_sample_feeder: directed self-checking bench for tx_sample_feeder.
module tb_tx_sample_feeder;
  logic        dac_clk = 1'b0;
  logic        rst = 1'b1;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = 8'd0;
  logic [31:0] set_data = 32'd0;
  logic [31:0] in_data = 32'd0;
  logic        in_eob = 1'b0;
  logic        in_src_rdy = 1'b0;
  logic        in_dst_rdy;
  logic [63:0] start_time = 64'd0;
  logic        start_time_valid = 1'b0;
  logic [63:0] vita_time = 64'd0;
  logic [31:0] sample;
  logic        run;
  logic        strobe = 1'b0;
  logic        err_stb;
  logic [2:0]  err_code;
  logic [15:0] underrun_count;
  logic [31:0] burst_samples;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] words [0:3];

  tx_sample_feeder #(.BASE(8'd0), .CNT_W(16)) dut (
    .dac_clk(dac_clk), .rst(rst), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .in_data(in_data), .in_eob(in_eob), .in_src_rdy(in_src_rdy), .in_dst_rdy(in_dst_rdy),
    .start_time(start_time), .start_time_valid(start_time_valid), .vita_time(vita_time),
    .sample(sample), .run(run), .strobe(strobe), .err_stb(err_stb), .err_code(err_code),
    .underrun_count(underrun_count), .burst_samples(burst_samples)
  );

  always #5 dac_clk = ~dac_clk;

  task automatic step();
    @(posedge dac_clk);
    #1;
    vita_time = vita_time + 64'd1;
  endtask

  task automatic look();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    words[0] = 32'h1111_aaaa;
    words[1] = 32'h2222_bbbb;
    words[2] = 32'h3333_cccc;
    words[3] = 32'h4444_dddd;
    step(); step();
    rst = 1'b0;
    look();
    chk("rst_run", run, 0);
    chk("rst_dst_rdy", in_dst_rdy, 0);
    chk("rst_sample", sample, 0);
    chk("rst_err_stb", err_stb, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_ucount", underrun_count, 0);
    chk("rst_bsamples", burst_samples, 0);

    // untimed 4-word burst, strobe every 4th cycle
    in_src_rdy = 1'b1;
    in_data = words[0];
    step();
    look();
    chk("u_run_up", run, 1);
    for (int k = 0; k < 4; k++) begin
      in_data = words[k];
      for (int w = 0; w < 3; w++) begin
        look();
        chk("u_no_pop", in_dst_rdy, 0);
        step();
      end
      strobe = 1'b1;
      in_eob = (k == 3);
      look();
      chk("u_sample", sample, words[k]);
      chk("u_pop", in_dst_rdy, 1);
      chk("u_err_stb", err_stb, (k == 3) ? 1 : 0);
      chk("u_err_code", err_code, (k == 3) ? 1 : 0);
      step();
      strobe = 1'b0;
      in_eob = 1'b0;
    end
    in_src_rdy = 1'b0;
    look();
    chk("u_run_down", run, 0);
    chk("u_bsamples", burst_samples, 4);

    // timed burst at 1000
    start_time = 64'd1000;
    vita_time = 64'd990;
    start_time_valid = 1'b1;
    in_src_rdy = 1'b1;
    in_data = words[1];
    while (vita_time < 64'd1002) begin
      look();
      chk("t_run_low", run, 0);
      chk("t_no_pop", in_dst_rdy, 0);
      step();
    end
    look();
    chk("t_run_1002", run, 1);
    chk("t_bs_cleared", burst_samples, 0);
    chk("t_no_pop_run", in_dst_rdy, 0);
    strobe = 1'b1;
    in_eob = 1'b1;
    look();
    chk("t_ack", err_code, 1);
    step();
    strobe = 1'b0;
    in_eob = 1'b0;
    in_src_rdy = 1'b0;
    start_time_valid = 1'b0;
    look();
    chk("t_run_down", run, 0);
    chk("t_bsamples", burst_samples, 1);

    // late burst
    start_time = 64'd500;
    vita_time = 64'd600;
    start_time_valid = 1'b1;
    in_src_rdy = 1'b1;
    step();
    look();
    chk("l_stb", err_stb, 1);
    chk("l_code", err_code, 4);
    chk("l_run", run, 0);
    chk("l_no_pop", in_dst_rdy, 0);
    step();
    start_time_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_data = words[k];
      in_eob = (k == 2);
      look();
      chk("l_flush_pop", in_dst_rdy, 1);
      chk("l_flush_run", run, 0);
      chk("l_flush_noev", err_stb, 0);
      step();
    end
    in_eob = 1'b0;
    in_src_rdy = 1'b0;
    look();
    chk("l_idle_noev", err_stb, 0);
    chk("l_idle_run", run, 0);

    // policy 0 underrun
    in_src_rdy = 1'b1;
    in_data = words[0];
    step();
    strobe = 1'b1;
    look();
    chk("p0_pop0", in_dst_rdy, 1);
    step();
    in_src_rdy = 1'b0;
    look();
    chk("p0_ur_stb", err_stb, 1);
    chk("p0_ur_code", err_code, 2);
    chk("p0_ur_sample", sample, 0);
    step();
    strobe = 1'b0;
    look();
    chk("p0_ucount", underrun_count, 1);
    chk("p0_run", run, 0);
    in_src_rdy = 1'b1;
    for (int k = 1; k < 3; k++) begin
      in_data = words[k];
      in_eob = (k == 2);
      look();
      chk("p0_drop", in_dst_rdy, 1);
      chk("p0_no_ack", err_stb, 0);
      step();
    end
    in_eob = 1'b0;
    in_src_rdy = 1'b0;
    look();
    chk("p0_done_run", run, 0);
    chk("p0_bsamples", burst_samples, 1);

    // policy 1 underrun
    set_stb = 1'b1;
    set_data = 32'd2;
    step();
    set_stb = 1'b0;
    in_src_rdy = 1'b1;
    in_data = words[0];
    step();
    strobe = 1'b1;
    look();
    chk("p1_pop0", in_dst_rdy, 1);
    step();
    in_src_rdy = 1'b0;
    look();
    chk("p1_ur_code", err_code, 2);
    chk("p1_ur_sample", sample, 0);
    step();
    look();
    chk("p1_run_kept", run, 1);
    chk("p1_ucount", underrun_count, 2);
    in_src_rdy = 1'b1;
    in_data = words[1];
    look();
    chk("p1_resume_sample", sample, words[1]);
    chk("p1_resume_pop", in_dst_rdy, 1);
    step();
    in_data = words[2];
    in_eob = 1'b1;
    look();
    chk("p1_ack", err_code, 1);
    step();
    strobe = 1'b0;
    in_eob = 1'b0;
    in_src_rdy = 1'b0;
    look();
    chk("p1_run_down", run, 0);
    chk("p1_bsamples", burst_samples, 3);

    // clear together with a strobe mid-RUN
    in_src_rdy = 1'b1;
    in_data = words[3];
    step();
    strobe = 1'b1;
    step();
    set_stb = 1'b1;
    set_data = 32'd3;
    look();
    chk("c_no_pop", in_dst_rdy, 0);
    chk("c_no_ev", err_stb, 0);
    step();
    set_stb = 1'b0;
    strobe = 1'b0;
    in_src_rdy = 1'b0;
    look();
    chk("c_run", run, 0);
    chk("c_bsamples", burst_samples, 0);
    chk("c_ucount", underrun_count, 0);

    // saturation with policy 1 kept by the clear write
    in_src_rdy = 1'b1;
    step();
    in_src_rdy = 1'b0;
    strobe = 1'b1;
    for (int i = 0; i < 65535; i++) step();
    look();
    chk("s_sat", underrun_count, 16'hffff);
    for (int i = 0; i < 5; i++) step();
    look();
    chk("s_sat_hold", underrun_count, 16'hffff);
    chk("s_still_ur", err_code, 2);

    // rst mid-burst also restores policy 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    strobe = 1'b0;
    look();
    chk("r_run", run, 0);
    chk("r_ucount", underrun_count, 0);
    chk("r_bsamples", burst_samples, 0);
    in_src_rdy = 1'b1;
    step();
    in_src_rdy = 1'b0;
    strobe = 1'b1;
    look();
    chk("r_ur_code", err_code, 2);
    step();
    strobe = 1'b0;
    look();
    chk("r_policy0_flush", run, 0);
    in_src_rdy = 1'b1;
    in_eob = 1'b1;
    look();
    chk("r_flush_pop", in_dst_rdy, 1);
    step();
    in_src_rdy = 1'b0;
    in_eob = 1'b0;
    look();
    chk("r_flush_noev", err_stb, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
